// File: rtl/ble_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ble_rx_pkg
// Purpose  : Shared types and constants for the BLE link-layer receiver:
//            receiver state encoding, frame field lengths, the advertising
//            access address and the default CRC polynomial/seed.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ble_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } state_t;

    localparam int          HEADER_BITS      = 16;
    localparam int          CRC_BITS         = 24;
    localparam logic [31:0] BLE_ADV_AA       = 32'h8E89BED6;
    localparam logic [23:0] DEFAULT_CRC_POLY = 24'h00065B;
    localparam logic [23:0] DEFAULT_CRC_INIT = 24'h555555;

endpackage : ble_rx_pkg
`default_nettype wire

// File: rtl/ble_lfsr_dewhiten_crc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ble_lfsr_dewhiten_crc
// Purpose  : Combined 7-bit dewhitening LFSR and 24-bit CRC engine. A seed
//            pulse makes the current bit use the channel seed / CRC seed
//            instead of the stored state, so the first bit of a frame is
//            processed in the same cycle the frame is detected.
// Ports    : symbol_clk   - clock, posedge
//            rst          - asynchronous active-low reset
//            channel      - channel index, forms the whitening seed
//            seed         - use seed values for the bit processed this cycle
//            step         - advance LFSR and CRC by one bit
//            din          - raw received bit
//            dout         - dewhitened bit (combinational)
//            residue_zero - CRC value after this step is all zero
// Revision : 1.0 - initial release
// ============================================================================
module ble_lfsr_dewhiten_crc
    import ble_rx_pkg::*;
#(
    parameter logic [23:0] CRC_POLY    = DEFAULT_CRC_POLY,
    parameter logic [23:0] CRC_INIT    = DEFAULT_CRC_INIT,
    parameter bit          DEWHITEN_EN = 1'b1
) (
    input  logic       symbol_clk,
    input  logic       rst,
    input  logic [5:0] channel,
    input  logic       seed,
    input  logic       step,
    input  logic       din,
    output logic       dout,
    output logic       residue_zero
);

    logic [6:0]  r_lfsr;
    logic [6:0]  w_lfsr_cur;
    logic [6:0]  w_lfsr_nxt;
    logic [23:0] r_crc;
    logic [23:0] w_crc_cur;
    logic [23:0] w_crc_nxt;
    logic        w_fb;

    always_comb begin
        w_lfsr_cur = seed ? {1'b1, channel} : r_lfsr;
        w_crc_cur  = seed ? CRC_INIT : r_crc;

        dout = DEWHITEN_EN ? (din ^ w_lfsr_cur[0]) : din;

        // Rotate right; the bit leaving position 0 is also folded into bit 2.
        w_lfsr_nxt    = {w_lfsr_cur[0], w_lfsr_cur[6:1]};
        w_lfsr_nxt[2] = w_lfsr_nxt[2] ^ w_lfsr_cur[0];

        w_fb      = w_crc_cur[23] ^ dout;
        w_crc_nxt = {w_crc_cur[22:0], 1'b0} ^ (w_fb ? CRC_POLY : 24'h000000);
    end

    assign residue_zero = (w_crc_nxt == 24'h000000);

    always_ff @(posedge symbol_clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= '0;
            r_crc  <= '0;
        end else if (step) begin
            r_lfsr <= w_lfsr_nxt;
            r_crc  <= w_crc_nxt;
        end
    end

endmodule : ble_lfsr_dewhiten_crc
`default_nettype wire

// File: rtl/ble_packet_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ble_packet_rx
// Purpose  : Bit-serial BLE link-layer receiver. Hunts for any of NUM_AA
//            programmable access addresses, dewhitens, parses the 16-bit PDU
//            header, frames the payload by the length byte, and checks the
//            24-bit CRC once at frame end. Decoded bytes stream out.
// Ports    : symbol_clk - clock, posedge
//            rst        - asynchronous active-low reset
//            en         - receiver enable; low returns to hunting
//            symbol_in  - sliced symbol
//            acc_addr   - packed access addresses, slot i at [i*LEN +: LEN]
//            aa_enable  - per-slot match enable
//            channel    - channel index (whitening seed)
//            byte_out   - decoded header/payload byte
//            byte_valid - strobe qualifying byte_out
//            pkt_start  - strobe after an access-address match
//            pkt_done   - strobe at frame end or on length error
//            crc_ok     - CRC result, valid with pkt_done
//            len_error  - strobe, header length above MAX_PDU_LEN
//            aa_idx     - matched slot
//            pdu_len    - header length byte
//            busy       - frame in progress
// Revision : 1.0 - initial release
// ============================================================================
module ble_packet_rx
    import ble_rx_pkg::*;
#(
    parameter int          NUM_AA       = 4,
    parameter int          ACC_ADDR_LEN = 32,
    parameter int          MAX_PDU_LEN  = 255,
    parameter logic [23:0] CRC_POLY     = DEFAULT_CRC_POLY,
    parameter logic [23:0] CRC_INIT     = DEFAULT_CRC_INIT,
    parameter bit          DEWHITEN_EN  = 1'b1
) (
    input  logic                                          symbol_clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic                                          symbol_in,
    input  logic [NUM_AA*ACC_ADDR_LEN-1:0]                acc_addr,
    input  logic [NUM_AA-1:0]                             aa_enable,
    input  logic [5:0]                                    channel,
    output logic [7:0]                                    byte_out,
    output logic                                          byte_valid,
    output logic                                          pkt_start,
    output logic                                          pkt_done,
    output logic                                          crc_ok,
    output logic                                          len_error,
    output logic [((NUM_AA > 1) ? $clog2(NUM_AA) : 1)-1:0] aa_idx,
    output logic [7:0]                                    pdu_len,
    output logic                                          busy
);

    localparam int          AA_IDX_W  = (NUM_AA > 1) ? $clog2(NUM_AA) : 1;
    localparam logic [7:0]  C_MAX_LEN = 8'(MAX_PDU_LEN);
    localparam logic [10:0] C_HDR_LAST = 11'(HEADER_BITS - 1);
    localparam logic [10:0] C_CRC_LAST = 11'(CRC_BITS - 1);

    state_t                  r_state, w_state_nxt;
    logic [ACC_ADDR_LEN-1:0] r_aa_sr;
    logic [10:0]             r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]              r_shift, w_shift_nxt;
    logic [7:0]              w_byte;
    logic [10:0]             w_pl_last;

    logic [NUM_AA-1:0]       w_slot_hit;
    logic                    w_match;
    logic [AA_IDX_W-1:0]     w_match_idx;

    logic                    w_seed, w_step, w_d, w_residue_zero;

    logic [7:0]              w_byte_out_nxt, w_pdu_len_nxt;
    logic                    w_byte_valid_nxt, w_pkt_start_nxt, w_pkt_done_nxt;
    logic                    w_crc_ok_nxt, w_len_error_nxt, w_busy_nxt;
    logic [AA_IDX_W-1:0]     w_aa_idx_nxt;

    // ------------------------------------------------------------------
    // Access-address comparators
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_AA; gi++) begin : g_slot
            assign w_slot_hit[gi] = aa_enable[gi] &&
                (r_aa_sr == acc_addr[gi*ACC_ADDR_LEN +: ACC_ADDR_LEN]);
        end
    endgenerate

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = NUM_AA - 1; i >= 0; i--) begin
            if (w_slot_hit[i]) begin
                w_match     = 1'b1;
                w_match_idx = AA_IDX_W'(i);
            end
        end
    end

    ble_lfsr_dewhiten_crc #(
        .CRC_POLY    (CRC_POLY),
        .CRC_INIT    (CRC_INIT),
        .DEWHITEN_EN (DEWHITEN_EN)
    ) u_engine (
        .symbol_clk   (symbol_clk),
        .rst          (rst),
        .channel      (channel),
        .seed         (w_seed),
        .step         (w_step),
        .din          (symbol_in),
        .dout         (w_d),
        .residue_zero (w_residue_zero)
    );

    assign w_byte    = {w_d, r_shift[7:1]};
    // Index of the last payload bit: pdu_len*8 - 1 (pdu_len >= 1 here).
    assign w_pl_last = {r_pdu_len_m1(pdu_len), 3'b111};

    function automatic logic [7:0] r_pdu_len_m1(input logic [7:0] len);
        return len - 8'd1;
    endfunction

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_byte_out_nxt   = byte_out;
        w_byte_valid_nxt = 1'b0;
        w_pkt_start_nxt  = 1'b0;
        w_pkt_done_nxt   = 1'b0;
        w_len_error_nxt  = 1'b0;
        w_crc_ok_nxt     = crc_ok;
        w_aa_idx_nxt     = aa_idx;
        w_pdu_len_nxt    = pdu_len;
        w_seed           = 1'b0;
        w_step           = 1'b0;

        if (!en) begin
            w_state_nxt   = ST_HUNT;
            w_bit_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_match) begin
                        // The bit arriving on the match edge is header bit 0.
                        w_seed          = 1'b1;
                        w_step          = 1'b1;
                        w_shift_nxt     = w_byte;
                        w_bit_cnt_nxt   = 11'd1;
                        w_state_nxt     = ST_HEADER;
                        w_aa_idx_nxt    = w_match_idx;
                        w_pkt_start_nxt = 1'b1;
                        w_crc_ok_nxt    = 1'b0;
                        w_pdu_len_nxt   = 8'd0;
                    end
                end

                ST_HEADER: begin
                    w_step      = 1'b1;
                    w_shift_nxt = w_byte;
                    if (r_bit_cnt[2:0] == 3'b111) begin
                        w_byte_out_nxt   = w_byte;
                        w_byte_valid_nxt = 1'b1;
                    end
                    if (r_bit_cnt == C_HDR_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_pdu_len_nxt = w_byte;
                        if (w_byte > C_MAX_LEN) begin
                            w_len_error_nxt = 1'b1;
                            w_pkt_done_nxt  = 1'b1;
                            w_crc_ok_nxt    = 1'b0;
                            w_state_nxt     = ST_HUNT;
                        end else if (w_byte == 8'd0) begin
                            w_state_nxt = ST_CRC;
                        end else begin
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 11'd1;
                    end
                end

                ST_PAYLOAD: begin
                    w_step      = 1'b1;
                    w_shift_nxt = w_byte;
                    if (r_bit_cnt[2:0] == 3'b111) begin
                        w_byte_out_nxt   = w_byte;
                        w_byte_valid_nxt = 1'b1;
                    end
                    if (r_bit_cnt == w_pl_last) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_CRC;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 11'd1;
                    end
                end

                ST_CRC: begin
                    w_step = 1'b1;
                    if (r_bit_cnt == C_CRC_LAST) begin
                        w_bit_cnt_nxt  = '0;
                        w_pkt_done_nxt = 1'b1;
                        w_crc_ok_nxt   = w_residue_zero;
                        w_state_nxt    = ST_HUNT;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 11'd1;
                    end
                end

                default: begin
                    w_state_nxt   = ST_HUNT;
                    w_bit_cnt_nxt = '0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != ST_HUNT);
    end

    always_ff @(posedge symbol_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_HUNT;
            r_aa_sr    <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;
            crc_ok     <= 1'b0;
            len_error  <= 1'b0;
            aa_idx     <= '0;
            pdu_len    <= '0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_aa_sr    <= {r_aa_sr[ACC_ADDR_LEN-2:0], symbol_in};
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            byte_out   <= w_byte_out_nxt;
            byte_valid <= w_byte_valid_nxt;
            pkt_start  <= w_pkt_start_nxt;
            pkt_done   <= w_pkt_done_nxt;
            crc_ok     <= w_crc_ok_nxt;
            len_error  <= w_len_error_nxt;
            aa_idx     <= w_aa_idx_nxt;
            pdu_len    <= w_pdu_len_nxt;
            busy       <= w_busy_nxt;
        end
    end

endmodule : ble_packet_rx
`default_nettype wire

// File: doc/ble_packet_rx.md
Name: ble_packet_rx

Overview:
- Parametrised successor to the single-address packet sniffer. Bit-serial BLE link-layer receiver with multi-access-address matching.
- Matches the incoming symbol stream against up to NUM_AA programmable access addresses. Dewhitens, parses the 16-bit PDU header and uses the length byte to frame the payload.
- Checks the 24-bit CRC at the exact frame end, not at every byte boundary. Streams decoded bytes out.
- Sits between the symbol slicer and the packet FIFO/host interface.

Parameters:
NUM_AA, 4, number of access-address comparators
ACC_ADDR_LEN, 32, access-address width in bits
MAX_PDU_LEN, 255, largest accepted payload length in bytes (1..255)
CRC_POLY, 24'h00065B, CRC polynomial (x^24 term implicit)
CRC_INIT, 24'h555555, CRC seed
DEWHITEN_EN, 1, 1 = dewhiten header/payload/CRC; 0 = pass raw bits

Ports:
symbol_clk  in  1  symbol clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
en  in  1  receiver enable; low forces HUNT
symbol_in  in  1  sliced symbol, sampled on posedge
acc_addr  in  NUM_AA*ACC_ADDR_LEN  packed access addresses; slot i = bits [i*32+:32]
aa_enable  in  NUM_AA  per-slot match enable
channel  in  6  channel index, dewhitening seed
byte_out  out  8  decoded header/payload byte, LSB-first assembly
byte_valid  out  1  one-cycle strobe qualifying byte_out
pkt_start  out  1  one-cycle strobe on access-address match
pkt_done  out  1  one-cycle strobe at frame end (normal or length error)
crc_ok  out  1  CRC result, valid with pkt_done
len_error  out  1  one-cycle strobe, header length > MAX_PDU_LEN
aa_idx  out  $clog2(NUM_AA) (min 1)  matched slot
pdu_len  out  8  header length byte
busy  out  1  high in HEADER/PAYLOAD/CRC

Behaviour:
- Reset and outputs:
  - All outputs reset to 0; state resets to HUNT; aa_sr resets to 0.
  - Outputs are registered. aa_idx, pdu_len and crc_ok hold until the next pkt_start.
- aa_sr (ACC_ADDR_LEN bits) shifts symbol_in in at every posedge in every state: aa_sr <= {aa_sr[30:0], symbol_in}.
- States: HUNT, HEADER, PAYLOAD, CRC.
- HUNT:
  - A match is aa_sr == slot i with aa_enable[i]=1 and en=1. If several slots match, the lowest index wins.
  - On the match edge, the symbol_in sampled at that edge is header bit 0 and is processed at once. State goes to HEADER, aa_idx is loaded, and pkt_start pulses in the next cycle.
  - The LFSRs are seeded on the match edge before processing bit 0.
- Dewhitening:
  - 7-bit LFSR, seed {1'b1, channel}. Output bit d = symbol_in ^ lfsr[0].
  - Next state = {lfsr[0], lfsr[6:1]}, with bit 2 additionally XORed with lfsr[0].
  - With DEWHITEN_EN=0, d = symbol_in.
- CRC:
  - fb = crc[23] ^ d; crc <= {crc[22:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - Runs over the header, payload and the 24 received CRC bits. crc_ok = residue == 0 after the last CRC bit.
- Byte assembly: shift = {d, shift[7:1]}. On every 8th header/payload bit, byte_out and byte_valid are registered. CRC bits produce no bytes.
- HEADER: 16 bits. On bit 15 the length byte is evaluated.
  - Length > MAX_PDU_LEN: len_error and pkt_done pulse, crc_ok=0, state goes to HUNT.
  - Length == 0: state goes to CRC.
  - Otherwise: state goes to PAYLOAD.
  - pdu_len is latched at this point in all cases.
- PAYLOAD: pdu_len*8 bits counted by a 11-bit counter, then state goes to CRC.
- CRC: 24 bits. On the last bit, pkt_done pulses with crc_ok, then state goes to HUNT.
- Re-hunt latency: a new match is allowed on the edge directly after the HUNT re-entry, because aa_sr never stops shifting.
- Abort and reset cases:
  - en low in any state: on the next edge, state goes to HUNT and the counters clear. No pkt_done and no further byte_valid.
  - Async reset mid-frame: immediate return to the reset state.

Decomposition:
- Package ble_rx_pkg holds:
  - state enum
  - HEADER_BITS=16, CRC_BITS=24, BLE_ADV_AA=32'h8E89BED6
  - default CRC_POLY/CRC_INIT
- Sub-module ble_lfsr_dewhiten_crc: combined dewhitening LFSR and CRC engine, with seed, step and residue-zero ports.

Test Plan:
- Valid advertising frame: slot0=0x8E89BED6 enabled, channel 37, header 0x02 0x06, 6-byte payload, correct CRC from the software model -> pkt_start once; 8 byte_valid strobes in order 0x02,0x06,payload; pkt_done with crc_ok=1, aa_idx=0, pdu_len=6.
- Same frame with payload bit 17 flipped -> 8 byte_valid strobes; pkt_done with crc_ok=0.
- Slot0 and slot2 both hold 0x8E89BED6, aa_enable=4'b0101 -> aa_idx=0. Then aa_enable=4'b0100 -> aa_idx=2. With aa_enable=0 -> no pkt_start.
- MAX_PDU_LEN=37, header length 38 -> 2 byte_valid strobes; len_error and pkt_done in the same cycle, crc_ok=0, busy low next cycle.
- Zero-length PDU, header 0x00 0x00 with valid CRC -> 2 byte_valid strobes; pkt_done exactly 24 edges after the last header bit, crc_ok=1.
- en dropped at payload bit 20 -> busy low next cycle, no pkt_done. A back-to-back valid frame after en returns decodes correctly. rst pulsed mid-CRC -> all outputs 0.
